// File: rtl/dice_turn_if.sv
// dice_turn_if: detector pulses, enable and move handshake between the game side and the dice turn controller
interface dice_turn_if;
   logic       enable;
   logic       frame_start;
   logic       color_valid;
   logic [1:0] dominant_color;
   logic       white_detected;
   logic       move_ack;
   logic       move_req;
   logic [1:0] move_steps;
   logic [1:0] player_id;
   logic       turn_done;
   logic [1:0] locked_color;
   logic [2:0] state;
   modport master (
      output enable, frame_start, color_valid, dominant_color, white_detected, move_ack,
      input  move_req, move_steps, player_id, turn_done, locked_color, state
   );
   modport slave (
      input  enable, frame_start, color_valid, dominant_color, white_detected, move_ack,
      output move_req, move_steps, player_id, turn_done, locked_color, state
   );
endinterface

// File: rtl/dice_turn_controller.sv
// dice_turn_controller: qualifies a dice color over consecutive frames, issues one move request per turn
module dice_turn_controller #(
   parameter int STABLE_FRAMES = 4,
   parameter int WHITE_FRAMES  = 3,
   parameter int NUM_PLAYERS   = 2
) (
   input logic        clk,
   input logic        reset,
   dice_turn_if.slave dt
);
   typedef enum logic [2:0] {IDLE = 3'd0, ARMED = 3'd1, QUALIFY = 3'd2, REQUEST = 3'd3, WAIT_REMOVE = 3'd4} state_t;
   localparam logic [7:0] SF   = 8'(STABLE_FRAMES);
   localparam logic [7:0] WF   = 8'(WHITE_FRAMES);
   localparam logic [1:0] LAST = 2'(NUM_PLAYERS - 1);
   state_t     st, st_n;
   logic       fs_q, eval;
   logic [7:0] wcnt, wcnt_n, cnt, cnt_n, wcnt_inc, cnt_inc;
   logic [1:0] cand, cand_n, player, player_n, steps, locked;
   logic       done, done_n;
   logic       is_color, is_white, is_none;
   // detector pulses are only meaningful in the cycle after the frame_start edge
   assign is_color = eval & dt.color_valid;
   assign is_white = eval & ~dt.color_valid & dt.white_detected;
   assign is_none  = eval & ~dt.color_valid & ~dt.white_detected;
   assign wcnt_inc = wcnt == 8'hFF ? wcnt : wcnt + 8'd1;
   assign cnt_inc  = cnt == 8'hFF ? cnt : cnt + 8'd1;
   always_comb begin
      st_n     = st;
      wcnt_n   = wcnt;
      cnt_n    = cnt;
      cand_n   = cand;
      player_n = player;
      done_n   = 1'b0;
      if (!dt.enable) begin
         st_n   = IDLE;
         wcnt_n = '0;
         cnt_n  = '0;
         cand_n = '0;
      end else begin
         case (st)
            IDLE, WAIT_REMOVE: begin
               if (is_white) begin
                  wcnt_n = wcnt_inc;
                  if (wcnt_inc == WF) begin
                     wcnt_n = '0;
                     st_n   = ARMED;
                     if (st == WAIT_REMOVE) begin
                        done_n   = 1'b1;
                        player_n = player == LAST ? 2'd0 : player + 2'd1;
                     end
                  end
               end else if (is_color || is_none) begin
                  wcnt_n = '0;
               end
            end
            ARMED: begin
               if (is_color) begin
                  cand_n = dt.dominant_color;
                  cnt_n  = 8'd1;
                  st_n   = SF == 8'd1 ? REQUEST : QUALIFY;
               end
            end
            QUALIFY: begin
               if (is_color && dt.dominant_color == cand) begin
                  cnt_n = cnt_inc;
                  if (cnt_inc == SF) st_n = REQUEST;
               end else if (is_color) begin
                  cand_n = dt.dominant_color;
                  cnt_n  = 8'd1;
               end else if (is_white) begin
                  cnt_n = '0;
                  st_n  = ARMED;
               end
            end
            REQUEST: begin
               if (dt.move_ack) begin
                  cnt_n = '0;
                  st_n  = WAIT_REMOVE;
               end
            end
            default: st_n = IDLE;
         endcase
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st     <= IDLE;
         fs_q   <= 1'b0;
         eval   <= 1'b0;
         wcnt   <= '0;
         cnt    <= '0;
         cand   <= '0;
         player <= '0;
         steps  <= '0;
         locked <= '0;
         done   <= 1'b0;
      end else begin
         st     <= st_n;
         fs_q   <= dt.frame_start;
         eval   <= dt.frame_start & ~fs_q;
         wcnt   <= wcnt_n;
         cnt    <= cnt_n;
         cand   <= cand_n;
         player <= player_n;
         done   <= done_n;
         // color codes R/G/B map directly onto step counts 1/2/3
         if (st_n == REQUEST && st != REQUEST) begin
            steps  <= cand_n;
            locked <= cand_n;
         end
      end
   end
   assign dt.move_req     = st == REQUEST;
   assign dt.move_steps   = steps;
   assign dt.player_id    = player;
   assign dt.turn_done    = done;
   assign dt.locked_color = locked;
   assign dt.state        = st;
endmodule

// File: tb/tb_dice_turn_controller.sv
// tb_dice_turn_controller: directed scenarios for the dice turn controller with three players
module tb_dice_turn_controller;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   errors = 0;
   int   checks = 0;
   int   done_cnt = 0;
   dice_turn_if dt ();
   dice_turn_controller #(.STABLE_FRAMES(4), .WHITE_FRAMES(3), .NUM_PLAYERS(3)) dut (
      .clk(clk), .reset(reset), .dt(dt)
   );
   always #5 clk = ~clk;
   always @(negedge clk) if (dt.turn_done === 1'b1) done_cnt++;
   // c != 0 gives a color result, otherwise w selects WHITE versus NONE; returns one cycle after eval
   task automatic frame(input logic [1:0] c, input logic w);
      @(posedge clk); #1 dt.frame_start = 1'b1;
      @(posedge clk); #1 dt.frame_start = 1'b0;
      dt.color_valid    = c != 2'd0;
      dt.dominant_color = c;
      dt.white_detected = w;
      @(posedge clk); #1 dt.color_valid = 1'b0;
      dt.dominant_color = 2'd0;
      dt.white_detected = 1'b0;
   endtask
   task automatic ack_cycle();
      @(posedge clk); #1 dt.move_ack = 1'b1;
      @(posedge clk); #1 dt.move_ack = 1'b0;
   endtask
   task automatic end_turn();
      ack_cycle();
      repeat (3) frame(2'd0, 1'b1);
   endtask
   task automatic test_reset();
      #12;
      checks++; if (dt.state !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", dt.state); end
      checks++; if (dt.move_req !== 1'b0) begin errors++; $display("FAIL reset_move_req got=%b exp=0", dt.move_req); end
      checks++; if (dt.move_steps !== 2'd0) begin errors++; $display("FAIL reset_steps got=%0d exp=0", dt.move_steps); end
      checks++; if (dt.player_id !== 2'd0) begin errors++; $display("FAIL reset_player got=%0d exp=0", dt.player_id); end
      checks++; if (dt.turn_done !== 1'b0) begin errors++; $display("FAIL reset_turn_done got=%b exp=0", dt.turn_done); end
      checks++; if (dt.locked_color !== 2'd0) begin errors++; $display("FAIL reset_locked got=%0d exp=0", dt.locked_color); end
      @(posedge clk); #1 reset = 1'b0;
   endtask
   task automatic test_arming();
      dt.enable = 1'b1;
      frame(2'd0, 1'b1);
      frame(2'd0, 1'b1);
      frame(2'd0, 1'b0);
      frame(2'd0, 1'b1);
      frame(2'd0, 1'b1);
      checks++; if (dt.state !== 3'd0) begin errors++; $display("FAIL arm_early got=%0d exp=0", dt.state); end
      frame(2'd0, 1'b1);
      checks++; if (dt.state !== 3'd1) begin errors++; $display("FAIL arm_done got=%0d exp=1", dt.state); end
   endtask
   task automatic test_qualify();
      repeat (3) frame(2'd1, 1'b0);
      checks++; if (dt.state !== 3'd2 || dt.move_req !== 1'b0) begin errors++; $display("FAIL red3 state=%0d req=%b exp=2/0", dt.state, dt.move_req); end
      frame(2'd1, 1'b0);
      checks++; if (dt.move_req !== 1'b1 || dt.move_steps !== 2'd1) begin errors++; $display("FAIL red4 req=%b steps=%0d exp=1/1", dt.move_req, dt.move_steps); end
      checks++; if (dt.locked_color !== 2'd1 || dt.state !== 3'd3) begin errors++; $display("FAIL red4_lock locked=%0d state=%0d exp=1/3", dt.locked_color, dt.state); end
      ack_cycle();
      checks++; if (dt.state !== 3'd4 || dt.move_req !== 1'b0) begin errors++; $display("FAIL red_ack state=%0d req=%b exp=4/0", dt.state, dt.move_req); end
      repeat (3) frame(2'd0, 1'b1);
      checks++; if (dt.player_id !== 2'd1 || dt.state !== 3'd1) begin errors++; $display("FAIL red_turn player=%0d state=%0d exp=1/1", dt.player_id, dt.state); end
      repeat (3) frame(2'd1, 1'b0);
      repeat (3) frame(2'd3, 1'b0);
      checks++; if (dt.move_req !== 1'b0 || dt.state !== 3'd2) begin errors++; $display("FAIL blue3 req=%b state=%0d exp=0/2", dt.move_req, dt.state); end
      frame(2'd3, 1'b0);
      checks++; if (dt.move_req !== 1'b1 || dt.move_steps !== 2'd3) begin errors++; $display("FAIL blue4 req=%b steps=%0d exp=1/3", dt.move_req, dt.move_steps); end
      end_turn();
   endtask
   task automatic test_none_tolerance();
      frame(2'd1, 1'b0);
      frame(2'd0, 1'b0);
      frame(2'd1, 1'b0);
      frame(2'd1, 1'b0);
      checks++; if (dt.move_req !== 1'b0) begin errors++; $display("FAIL none_early req=%b exp=0", dt.move_req); end
      frame(2'd1, 1'b0);
      checks++; if (dt.move_req !== 1'b1) begin errors++; $display("FAIL none_5th req=%b exp=1", dt.move_req); end
      end_turn();
      checks++; if (dt.player_id !== 2'd0) begin errors++; $display("FAIL none_player got=%0d exp=0", dt.player_id); end
      frame(2'd1, 1'b0);
      frame(2'd1, 1'b0);
      frame(2'd0, 1'b1);
      checks++; if (dt.state !== 3'd1) begin errors++; $display("FAIL white_drop state=%0d exp=1", dt.state); end
      repeat (3) frame(2'd1, 1'b0);
      checks++; if (dt.move_req !== 1'b0 || dt.state !== 3'd2) begin errors++; $display("FAIL restart3 req=%b state=%0d exp=0/2", dt.move_req, dt.state); end
      frame(2'd1, 1'b0);
      checks++; if (dt.move_req !== 1'b1) begin errors++; $display("FAIL restart4 req=%b exp=1", dt.move_req); end
      end_turn();
   endtask
   task automatic test_handshake();
      repeat (4) frame(2'd2, 1'b0);
      repeat (10) @(posedge clk);
      #1 frame(2'd3, 1'b0);
      frame(2'd0, 1'b1);
      checks++; if (dt.move_req !== 1'b1 || dt.move_steps !== 2'd2) begin errors++; $display("FAIL hold req=%b steps=%0d exp=1/2", dt.move_req, dt.move_steps); end
      ack_cycle();
      checks++; if (dt.move_req !== 1'b0 || dt.state !== 3'd4) begin errors++; $display("FAIL green_ack req=%b state=%0d exp=0/4", dt.move_req, dt.state); end
      repeat (3) frame(2'd0, 1'b1);
      checks++; if (dt.player_id !== 2'd2) begin errors++; $display("FAIL green_player got=%0d exp=2", dt.player_id); end
   endtask
   task automatic test_rotation();
      logic [1:0] exp_p;
      int base;
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      repeat (3) frame(2'd0, 1'b1);
      exp_p = 2'd0;
      for (int t = 0; t < 3; t++) begin
         repeat (4) frame(2'd1, 1'b0);
         ack_cycle();
         base = done_cnt;
         frame(2'd0, 1'b1);
         frame(2'd0, 1'b1);
         frame(2'd1, 1'b0);
         frame(2'd0, 1'b1);
         frame(2'd0, 1'b1);
         checks++; if (dt.state !== 3'd4 || done_cnt != base) begin errors++; $display("FAIL rot_pre%0d state=%0d pulses=%0d exp=4/0", t, dt.state, done_cnt - base); end
         frame(2'd0, 1'b1);
         exp_p = exp_p == 2'd2 ? 2'd0 : exp_p + 2'd1;
         checks++; if (dt.turn_done !== 1'b1 || dt.player_id !== exp_p || dt.state !== 3'd1) begin errors++; $display("FAIL rot_done%0d done=%b player=%0d state=%0d exp=1/%0d/1", t, dt.turn_done, dt.player_id, dt.state, exp_p); end
         @(posedge clk); #1;
         checks++; if (dt.turn_done !== 1'b0 || done_cnt != base + 1) begin errors++; $display("FAIL rot_pulse%0d done=%b pulses=%0d exp=0/1", t, dt.turn_done, done_cnt - base); end
      end
   endtask
   task automatic test_abort();
      repeat (4) frame(2'd1, 1'b0);
      checks++; if (dt.state !== 3'd3) begin errors++; $display("FAIL abort_pre state=%0d exp=3", dt.state); end
      @(posedge clk); #1 dt.enable = 1'b0;
      dt.move_ack = 1'b1;
      @(posedge clk); #1 dt.move_ack = 1'b0;
      checks++; if (dt.state !== 3'd0 || dt.move_req !== 1'b0) begin errors++; $display("FAIL abort state=%0d req=%b exp=0/0", dt.state, dt.move_req); end
      checks++; if (dt.player_id !== 2'd0 || dt.locked_color !== 2'd1) begin errors++; $display("FAIL abort_keep player=%0d locked=%0d exp=0/1", dt.player_id, dt.locked_color); end
      dt.enable = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      checks++; if (dt.move_req !== 1'b0 || dt.state !== 3'd0) begin errors++; $display("FAIL abort_after req=%b state=%0d exp=0/0", dt.move_req, dt.state); end
   endtask
   task automatic test_reset_qualify();
      repeat (3) frame(2'd0, 1'b1);
      frame(2'd2, 1'b0);
      frame(2'd2, 1'b0);
      checks++; if (dt.state !== 3'd2) begin errors++; $display("FAIL rq_pre state=%0d exp=2", dt.state); end
      #2 reset = 1'b1;
      #1;
      checks++; if (dt.state !== 3'd0 || dt.move_req !== 1'b0 || dt.turn_done !== 1'b0) begin errors++; $display("FAIL rq_async state=%0d req=%b done=%b exp=0/0/0", dt.state, dt.move_req, dt.turn_done); end
      checks++; if (dt.move_steps !== 2'd0 || dt.locked_color !== 2'd0 || dt.player_id !== 2'd0) begin errors++; $display("FAIL rq_regs steps=%0d locked=%0d player=%0d exp=0/0/0", dt.move_steps, dt.locked_color, dt.player_id); end
      @(posedge clk); #1 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (dt.move_req !== 1'b0 || dt.state !== 3'd0) begin errors++; $display("FAIL rq_after req=%b state=%0d exp=0/0", dt.move_req, dt.state); end
   endtask
   initial begin
      dt.enable         = 1'b0;
      dt.frame_start    = 1'b0;
      dt.color_valid    = 1'b0;
      dt.dominant_color = 2'd0;
      dt.white_detected = 1'b0;
      dt.move_ack       = 1'b0;
      test_reset();
      test_arming();
      test_qualify();
      test_none_tolerance();
      test_handshake();
      test_rotation();
      test_abort();
      test_reset_qualify();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/dice_turn_controller.md
# dice_turn_controller

Frame-rate sequencer that sits between the ROI color detector and the game FSM. It consumes the detector's per-frame result pulses and qualifies a dice color over several consecutive frames. It then issues a single move request (1/2/3 steps) for the current player and waits for the dice to be removed before ending the turn and rotating to the next player.

## Interface

Parameters:
- STABLE_FRAMES, 4: consecutive same-color frames required to accept a dice color (legal range 1..255).
- WHITE_FRAMES, 3: consecutive white frames required to arm, or to end a turn (legal range 1..255).
- NUM_PLAYERS, 2: number of players, legal range 2..4. player_id wraps modulo this value.

Ports:
- clk, input, 1: system clock. Single clock domain.
- reset, input, 1: asynchronous, active-high reset.
- enable, input, 1: game running. Low forces IDLE.
- frame_start, input, 1: same frame_start signal that drives the detector.
- color_valid, input, 1: detector pulse meaning an R/G/B frame result.
- dominant_color, input, 2: detector color code. 01 = R, 10 = G, 11 = B, 00 = none.
- white_detected, input, 1: detector pulse meaning a white-background frame result.
- move_ack, input, 1: game FSM accepts the move request.
- move_req, output, 1: move request, held high until acknowledged.
- move_steps, output, 2: step count, 1..3. Stable while move_req is high.
- player_id, output, 2: current player, 0..NUM_PLAYERS-1.
- turn_done, output, 1: single-cycle end-of-turn pulse.
- locked_color, output, 2: last accepted color code.
- state, output, 3: current FSM state, for debug and overlay.

## Operation

**Frame evaluation.**
- An internal rising-edge detector on frame_start produces eval, which is frame_start edge delayed by one cycle. This is the cycle in which the detector's pulses are valid.
- At each eval, the frame is classified:
  - COLOR(c) if color_valid = 1, with c = dominant_color.
  - Otherwise WHITE if white_detected = 1.
  - Otherwise NONE.
- If both color_valid and white_detected are high, COLOR wins.
- Detector pulses outside eval are ignored.

**FSM.** State encoding: IDLE = 0, ARMED = 1, QUALIFY = 2, REQUEST = 3, WAIT_REMOVE = 4.
- **IDLE:**
  - Count consecutive WHITE frames. COLOR or NONE clears the count.
  - When the count reaches WHITE_FRAMES, go to ARMED. A clean background is required before the first turn.
- **ARMED:**
  - COLOR(c) sets cand = c and cnt = 1. If STABLE_FRAMES = 1, go directly to REQUEST; otherwise go to QUALIFY.
  - WHITE and NONE keep the state.
- **QUALIFY:**
  - COLOR(cand) increments cnt. When cnt reaches STABLE_FRAMES, go to REQUEST.
  - COLOR(other) sets cand to the new color and cnt = 1.
  - WHITE sets cnt = 0 and returns to ARMED.
  - NONE holds cnt unchanged.
- **REQUEST:**
  - On entry, latch locked_color = cand and move_steps = cand (R→1, G→2, B→3).
  - move_req is 1 throughout this state.
  - move_ack = 1 moves to WAIT_REMOVE.
  - All frame results are ignored.
- **WAIT_REMOVE:**
  - Count consecutive WHITE frames. COLOR or NONE clears the count.
  - When the count reaches WHITE_FRAMES:
    - pulse turn_done;
    - set player_id = (player_id + 1) mod NUM_PLAYERS;
    - go to ARMED.

**Enable and reset behavior.**
- enable = 0 in any state: on the next edge go to IDLE and clear all counters, cand, and move_req.
- player_id and locked_color are preserved when enable drops; only reset clears them.

**Counters.** All counters are 8-bit and saturate at 255. Comparisons against the parameters are equality compares.

## Timing

**Reset values:**
- state = IDLE
- move_req = 0
- move_steps = 0
- player_id = 0
- turn_done = 0
- locked_color = 0
- all counters = 0

**Cycle-level behavior:**
- Frame result to state change: 1 cycle. The transition is registered at the edge ending the eval cycle.
- move_req rises 1 cycle after the eval of the STABLE_FRAMES-th matching frame. move_steps and locked_color become valid in the same cycle.
- Handshake:
  - move_req stays high until move_ack is sampled high; it drops on the next edge.
  - move_ack may already be high in the first cycle of move_req.
  - move_ack while move_req = 0 is ignored.
- turn_done is high for exactly one cycle, 1 cycle after the qualifying eval. player_id updates in the same cycle and state reads ARMED.
- Simultaneous events: enable = 0 overrides move_ack and eval in the same cycle.
- Reset mid-operation: asynchronous return to the reset values listed above. A move request is never re-issued after reset.

## Test plan

- **Arming:** enable = 1, 3 WHITE frames → state 0→1 after the third eval. A 2-WHITE, NONE, 3-WHITE sequence arms only after the last WHITE.
- **Qualify RED:** 4 consecutive RED frames → move_req = 1 and move_steps = 1 one cycle after the 4th eval. 3 RED, then 1 BLUE, then 3 BLUE → no request until the 4th BLUE, then move_steps = 3.
- **NONE tolerance:** RED, NONE, RED, RED, RED → request on the 5th frame. RED, RED, WHITE, RED → back to ARMED with cnt = 1; no request.
- **Handshake:**
  - GREEN request held for 10 cycles and 2 frame pulses without ack → move_req stays 1 and move_steps stays 2.
  - move_ack for 1 cycle → move_req = 0 next cycle and state = 4.
- **Turn end and rotation, NUM_PLAYERS = 3:**
  - Complete 3 turns, each ending with WHITE, WHITE, RED, WHITE, WHITE, WHITE → turn_done pulses exactly once per turn, after the final WHITE.
  - player_id sequence 0→1→2→0.
- **Abort/reset:**
  - enable = 0 in the same cycle as move_ack → state = IDLE and player_id unchanged.
  - reset asserted in QUALIFY → all outputs at reset values immediately.
